prod_accum: RTL

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/prod_accum.sv
// prod_accum: accumulates blocks of NTERMS signed products from an upstream
// MBITS x NBITS multiplier and issues one registered sum per block.
//
// Build option: define PROD_ACCUM_SAT_EN to clamp the running sum to the
// most positive / most negative ACCBITS value on signed overflow. Without it
// the running sum wraps modulo 2^ACCBITS. The overflow flag is set in both
// builds.
//
// Handshake: prod_valid is a one-cycle strobe with no back-pressure. Each
// cycle it is high, one product is consumed. acc_valid is a one-cycle strobe
// that is high in the cycle after the edge that consumed the last term of a
// block. acc_out/acc_ovf are stable outside that edge.
module prod_accum #(
  parameter int MBITS   = 12,
  parameter int NBITS   = 8,
  parameter int ACCBITS = 28,
  parameter int NTERMS  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prod_valid,
  input  logic [MBITS+NBITS-1:0]    prod,
  input  logic                      clear,
  output logic [ACCBITS-1:0]        acc_out,
  output logic                      acc_valid,
  output logic                      acc_ovf,
  output logic [$clog2(NTERMS):0]   term_cnt,
  output logic [1:0]                dbg_state_o
);

  localparam int PBITS = MBITS + NBITS;
  localparam int CNTW  = $clog2(NTERMS) + 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NTERMS - 1);

  // Elaboration-time sanity on the parameter set.
  if (ACCBITS < PBITS) begin : g_bad_accbits
    $error("prod_accum: ACCBITS must be >= MBITS+NBITS");
  end
  if (NTERMS < 2) begin : g_bad_nterms
    $error("prod_accum: NTERMS must be >= 2");
  end

  // IDLE: no terms held. RUN: 1..NTERMS-1 terms held. DONE: result just issued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACCBITS-1:0]  acc_q, acc_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic [ACCBITS-1:0]  out_q, out_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  logic [ACCBITS-1:0]  prod_ext;
  logic [ACCBITS-1:0]  sum_raw;
  logic                add_ovf;
  logic [ACCBITS-1:0]  add_res;

  // Sign-extend the product and form the running-sum candidate.
  always_comb begin
    prod_ext = ACCBITS'($signed(prod));
    sum_raw  = acc_q + prod_ext;
    // Overflow: both operands share a sign and the result sign differs.
    add_ovf  = (acc_q[ACCBITS-1] == prod_ext[ACCBITS-1]) &&
               (sum_raw[ACCBITS-1] != acc_q[ACCBITS-1]);
`ifdef PROD_ACCUM_SAT_EN
    // Clamp toward the sign of the operands when the add overflows.
    if (add_ovf) begin
      add_res = acc_q[ACCBITS-1] ? {1'b1, {(ACCBITS-1){1'b0}}}
                                 : {1'b0, {(ACCBITS-1){1'b1}}};
    end else begin
      add_res = sum_raw;
    end
`else
    add_res = sum_raw;
`endif
  end

  // Next-state and datapath control; clear takes priority over a new term.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    if (clear) begin
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (prod_valid) begin
            // First term of a block loads rather than adds: no overflow possible.
            state_d  = RUN;
            acc_d    = prod_ext;
            cnt_d    = CNTW'(1);
            sticky_d = 1'b0;
          end else if (state_q == DONE) begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (prod_valid) begin
            if (cnt_q == LAST_CNT) begin
              // Final term goes straight to the output register.
              state_d  = DONE;
              out_d    = add_res;
              ovf_d    = sticky_q | add_ovf;
              valid_d  = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
              sticky_d = 1'b0;
            end else begin
              acc_d    = add_res;
              cnt_d    = cnt_q + CNTW'(1);
              sticky_d = sticky_q | add_ovf;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign acc_out     = out_q;
  assign acc_ovf     = ovf_q;
  assign acc_valid   = valid_q;
  assign term_cnt    = cnt_q;
  assign dbg_state_o = state_q;

endmodule
